// File: rtl/store_forward_buffer.sv
// Circular store buffer with byte-granular store-to-load forwarding and a
// single-outstanding drain to dmem. Define STORE_BUF_COALESCE_EN to merge same-word pushes.
module store_forward_buffer #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [2:0]       st_funct3,
  input  logic [31:0]      st_wdata,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [2:0]       ld_funct3,
  output logic             ld_hit,
  output logic             ld_conflict,
  output logic [31:0]      ld_value,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_wmask,
  output logic [3:0]       dmem_rmask,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_resp,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [29:0]      addr_q [DEPTH];
  logic [3:0]       mask_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;
  state_t           state_q, state_d;

  logic        full, push_fire, alloc_fire, merge_ok, hold_head, issue, pop;
  logic [3:0]  push_mask;
  logic [31:0] push_data;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign st_ready = !full || merge_ok;
  assign push_fire  = st_valid && st_ready;
  assign alloc_fire = push_fire && !merge_ok;

  always_comb begin
    push_mask = 4'b0000;
    push_data = 32'h0;
    case (st_funct3)
      3'b000: begin
        push_mask = 4'b0001 << st_addr[1:0];
        push_data = {24'h0, st_wdata[7:0]} << {st_addr[1:0], 3'b000};
      end
      3'b001: begin
        push_mask = 4'b0011 << st_addr[1:0];
        push_data = {16'h0, st_wdata[15:0]} << {st_addr[1], 4'b0000};
      end
      3'b010: begin
        push_mask = 4'b1111;
        push_data = st_wdata;
      end
      default: ;
    endcase
  end

`ifdef STORE_BUF_COALESCE_EN
  logic [DEPTH-1:0] issued_q;
  logic [PTR_W-1:0] youngest;
  logic             merge_fire;
  logic [31:0]      merge_bits;

  assign youngest   = tail_q - 1'b1;
  assign merge_ok   = !empty && (addr_q[youngest] == st_addr[31:2]) && !issued_q[youngest];
  assign merge_fire = push_fire && merge_ok;
  // Defer issuing the head while it is still absorbing bytes, so a request never changes mid-flight.
  assign hold_head  = merge_fire && (youngest == head_q);
  assign merge_bits = {{8{push_mask[3]}}, {8{push_mask[2]}}, {8{push_mask[1]}}, {8{push_mask[0]}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
    end else begin
      if (alloc_fire) issued_q[tail_q] <= 1'b0;
      if (issue)      issued_q[head_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      addr_q[tail_q] <= st_addr[31:2];
      mask_q[tail_q] <= push_mask;
      data_q[tail_q] <= push_data;
    end else if (merge_fire) begin
      mask_q[youngest] <= mask_q[youngest] | push_mask;
      data_q[youngest] <= (data_q[youngest] & ~merge_bits) | (push_data & merge_bits);
    end
  end
`else
  assign merge_ok  = 1'b0;
  assign hold_head = 1'b0;

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      addr_q[tail_q] <= st_addr[31:2];
      mask_q[tail_q] <= push_mask;
      data_q[tail_q] <= push_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc_fire) tail_q <= tail_q + 1'b1;
      if (pop)        head_q <= head_q + 1'b1;
      count_q <= count_q + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Entries with an empty mask (unknown funct3) retire without touching memory.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !hold_head) begin
          if (mask_q[head_q] != 4'b0000) begin
            issue   = 1'b1;
            state_d = S_WAIT;
          end else begin
            pop = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (dmem_resp) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_addr  = 32'h0;
    dmem_wmask = 4'b0000;
    dmem_wdata = 32'h0;
    dmem_rmask = 4'b0000;
    if (state_q == S_WAIT || issue) begin
      dmem_addr  = {addr_q[head_q], 2'b00};
      dmem_wmask = mask_q[head_q];
      dmem_wdata = data_q[head_q];
    end
  end

  logic [3:0]       rmask, covered;
  logic             f3_ok, lk_active;
  logic [31:0]      merged, byte_sh, half_sh;
  logic [PTR_W-1:0] lk_idx;

  // Walk oldest to youngest so younger entries overwrite each lane.
  always_comb begin
    rmask   = 4'b0000;
    f3_ok   = 1'b1;
    covered = 4'b0000;
    merged  = 32'h0;
    lk_idx  = '0;
    case (ld_funct3)
      3'b000, 3'b100: rmask = 4'b0001 << ld_addr[1:0];
      3'b001, 3'b101: rmask = 4'b0011 << ld_addr[1:0];
      3'b010:         rmask = 4'b1111;
      default:        f3_ok = 1'b0;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (addr_q[lk_idx] == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (mask_q[lk_idx][b]) begin
            covered[b]      = 1'b1;
            merged[8*b +: 8] = data_q[lk_idx][8*b +: 8];
          end
        end
      end
    end
    covered   = covered & rmask;
    lk_active = ld_valid && !flush && f3_ok;
    byte_sh   = merged >> {ld_addr[1:0], 3'b000};
    half_sh   = merged >> {ld_addr[1], 4'b0000};
    ld_hit      = lk_active && (covered == rmask);
    ld_conflict = lk_active && (covered != 4'b0000) && (covered != rmask);
    ld_value    = 32'h0;
    if (ld_hit) begin
      case (ld_funct3)
        3'b000:  ld_value = {{24{byte_sh[7]}}, byte_sh[7:0]};
        3'b100:  ld_value = {24'h0, byte_sh[7:0]};
        3'b001:  ld_value = {{16{half_sh[15]}}, half_sh[15:0]};
        3'b101:  ld_value = {16'h0, half_sh[15:0]};
        default: ld_value = merged;
      endcase
    end
  end

endmodule

// File: tb/tb_store_forward_buffer.sv
// Randomized and directed bench for store_forward_buffer (default build), checked
// against a queue-of-stores reference model.
module tb_store_forward_buffer;
  localparam int DEPTH = 4;

  logic        clk, rst, flush;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_wdata;
  logic [2:0]  st_funct3;
  logic        ld_valid, ld_hit, ld_conflict;
  logic [31:0] ld_addr, ld_value;
  logic [2:0]  ld_funct3;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wmask, dmem_rmask;
  logic        dmem_resp;
  logic [2:0]  count;
  logic        empty;

  store_forward_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_funct3(st_funct3), .st_wdata(st_wdata),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .ld_hit(ld_hit), .ld_conflict(ld_conflict), .ld_value(ld_value),
    .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_rmask(dmem_rmask),
    .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0]     word;
    logic [3:0]      mask;
    logic [3:0][7:0] lane;
  } entry_t;

  entry_t mdl[$];
  bit     in_wait, pend_valid, pend_pop, pend_push, pend_wait;
  entry_t pend_entry;
  int     tests = 0;
  int     fails = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic entry_t makeEntry(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    entry_t e;
    int     o;
    e = '0;
    e.word = a[31:2];
    o = int'(a[1:0]);
    case (f3)
      3'b000: begin e.mask[o] = 1'b1; e.lane[o] = d[7:0]; end
      3'b001: begin
        e.mask[o] = 1'b1; e.mask[o+1] = 1'b1;
        e.lane[o] = d[7:0]; e.lane[o+1] = d[15:8];
      end
      3'b010: for (int i = 0; i < 4; i++) begin e.mask[i] = 1'b1; e.lane[i] = d[8*i +: 8]; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic modelLoad(input logic lv, input logic [31:0] la, input logic [2:0] lf, input logic fl,
                           output logic eh, output logic ec, output logic [31:0] ev);
    logic [3:0] rm, cov;
    logic [7:0] by [4];
    int         o;
    bit         ok;
    o = int'(la[1:0]);
    rm = 4'b0000; cov = 4'b0000; ok = 1'b1;
    eh = 1'b0; ec = 1'b0; ev = 32'h0;
    for (int b = 0; b < 4; b++) by[b] = 8'h00;
    case (lf)
      3'b000, 3'b100: rm[o] = 1'b1;
      3'b001, 3'b101: begin rm[o] = 1'b1; rm[o+1] = 1'b1; end
      3'b010:         rm = 4'b1111;
      default:        ok = 1'b0;
    endcase
    if (!lv || fl || !ok) return;
    for (int b = 0; b < 4; b++)
      if (rm[b])
        foreach (mdl[k])
          if (mdl[k].word == la[31:2] && mdl[k].mask[b]) begin cov[b] = 1'b1; by[b] = mdl[k].lane[b]; end
    eh = (cov == rm);
    ec = (cov != 4'b0000) && !eh;
    if (eh) begin
      case (lf)
        3'b000:  ev = {{24{by[o][7]}}, by[o]};
        3'b100:  ev = {24'h0, by[o]};
        3'b001:  ev = {{16{by[o+1][7]}}, by[o+1], by[o]};
        3'b101:  ev = {16'h0, by[o+1], by[o]};
        default: ev = {by[3], by[2], by[1], by[0]};
      endcase
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [2:0] sf,
                               input logic [31:0] sd, input logic lv, input logic [31:0] la,
                               input logic [2:0] lf, input logic fl, input logic rsp);
    logic        eh, ec;
    logic [31:0] ev, bm;
    bit          front_req, ready;
    @(negedge clk);
    if (pend_valid) begin
      if (pend_pop) void'(mdl.pop_front());
      if (pend_push) mdl.push_back(pend_entry);
      in_wait = pend_wait;
    end
    st_valid = sv; st_addr = sa; st_funct3 = sf; st_wdata = sd;
    ld_valid = lv; ld_addr = la; ld_funct3 = lf; flush = fl; dmem_resp = rsp;
    #1;
    ready     = mdl.size() < DEPTH;
    front_req = mdl.size() > 0 && mdl[0].mask != 4'b0000;
    checkOutput("st_ready", 32'(st_ready), 32'(ready));
    checkOutput("count", 32'(count), 32'(mdl.size()));
    checkOutput("empty", 32'(empty), 32'(mdl.size() == 0));
    checkOutput("dmem_rmask", 32'(dmem_rmask), 32'h0);
    if (front_req) begin
      bm = {{8{mdl[0].mask[3]}}, {8{mdl[0].mask[2]}}, {8{mdl[0].mask[1]}}, {8{mdl[0].mask[0]}}};
      checkOutput("dmem_addr", dmem_addr, {mdl[0].word, 2'b00});
      checkOutput("dmem_wmask", 32'(dmem_wmask), 32'(mdl[0].mask));
      checkOutput("dmem_wdata", dmem_wdata & bm, 32'(mdl[0].lane) & bm);
    end else begin
      checkOutput("dmem_addr_idle", dmem_addr, 32'h0);
      checkOutput("dmem_wmask_idle", 32'(dmem_wmask), 32'h0);
      checkOutput("dmem_wdata_idle", dmem_wdata, 32'h0);
    end
    modelLoad(lv, la, lf, fl, eh, ec, ev);
    checkOutput("ld_hit", 32'(ld_hit), 32'(eh));
    checkOutput("ld_conflict", 32'(ld_conflict), 32'(ec));
    if (eh || !lv || fl) checkOutput("ld_value", ld_value, ev);
    pend_pop   = mdl.size() > 0 && (mdl[0].mask == 4'b0000 || (in_wait && rsp));
    pend_wait  = in_wait ? !rsp : front_req;
    pend_push  = sv && ready;
    pend_entry = makeEntry(sa, sf, sd);
    pend_valid = 1'b1;
  endtask

  task automatic doStore(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d, input logic rsp);
    applyStimulus(1'b1, a, f3, d, 1'b0, 32'h0, 3'b000, 1'b0, rsp);
  endtask

  task automatic doLoad(input logic [31:0] a, input logic [2:0] f3, input logic rsp);
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, a, f3, 1'b0, rsp);
  endtask

  task automatic idle(input logic rsp);
    applyStimulus(1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0, rsp);
  endtask

  task automatic clearInputs();
    st_valid = 1'b0; st_addr = '0; st_funct3 = '0; st_wdata = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; flush = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic clearModel();
    mdl.delete();
    in_wait = 1'b0;
    pend_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      idle(1'b1);
      if (mdl.size() == 0 && !pend_push) break;
    end
    checkOutput("drain_bound", 32'(mdl.size()), 32'h0);
  endtask

  function automatic logic [31:0] pickWord();
    case ($urandom_range(0, 2))
      0:       return 32'h0000_1000;
      1:       return 32'h0000_1004;
      default: return 32'h0000_2000;
    endcase
  endfunction

  initial begin
    logic [2:0]  ld_opts [6];
    logic [2:0]  sf, lf;
    logic [31:0] sa, la;
    int          r;
    ld_opts = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    clearInputs();
    clearModel();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    idle(1'b0);
    checkOutput("reset_ready", 32'(st_ready), 32'h1);
    checkOutput("reset_empty", 32'(empty), 32'h1);
    checkOutput("reset_wmask", 32'(dmem_wmask), 32'h0);

    doStore(32'h0000_1000, 3'b010, 32'hDEAD_BEEF, 1'b0);
    idle(1'b0);
    checkOutput("sw_addr", dmem_addr, 32'h0000_1000);
    checkOutput("sw_wmask", 32'(dmem_wmask), 32'hF);
    checkOutput("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    idle(1'b0);
    checkOutput("sw_hold", dmem_wdata, 32'hDEAD_BEEF);
    idle(1'b1);
    idle(1'b0);
    checkOutput("sw_empty_after_resp", 32'(empty), 32'h1);

    doStore(32'h0000_2003, 3'b000, 32'h0000_00AB, 1'b0);
    doLoad(32'h0000_2003, 3'b000, 1'b0);
    checkOutput("lb_hit", 32'(ld_hit), 32'h1);
    checkOutput("lb_value", ld_value, 32'hFFFF_FFAB);
    doLoad(32'h0000_2003, 3'b100, 1'b0);
    checkOutput("lbu_value", ld_value, 32'h0000_00AB);
    doLoad(32'h0000_2002, 3'b001, 1'b0);
    checkOutput("lh_conflict", 32'(ld_conflict), 32'h1);
    drain();

    doStore(32'h0000_3000, 3'b010, 32'h1122_3344, 1'b0);
    doStore(32'h0000_3002, 3'b001, 32'h0000_BEEF, 1'b0);
    doLoad(32'h0000_3000, 3'b010, 1'b0);
    checkOutput("lw_merge", ld_value, 32'hBEEF_3344);
    drain();

    for (int i = 0; i < 4; i++) doStore(32'h0000_5000 + 32'(4 * i), 3'b010, 32'(i), 1'b0);
    doStore(32'h0000_5010, 3'b010, 32'h55, 1'b1);
    checkOutput("full_ready", 32'(st_ready), 32'h0);
    checkOutput("full_count", 32'(count), 32'h4);
    doStore(32'h0000_5010, 3'b010, 32'h55, 1'b0);
    checkOutput("after_pop_count", 32'(count), 32'h3);
    idle(1'b0);
    checkOutput("refill_count", 32'(count), 32'h4);
    for (int i = 0; i < 8; i++) doStore(32'h0000_6000 + 32'(4 * i), 3'b010, 32'(i + 100), 1'(i % 2));
    drain();

    doStore(32'h0000_7000, 3'b010, 32'h7777_7777, 1'b0);
    idle(1'b0);
    idle(1'b0);
    #2;
    clearInputs();
    rst = 1'b1;
    #1;
    checkOutput("rst_wmask", 32'(dmem_wmask), 32'h0);
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_ready", 32'(st_ready), 32'h1);
    clearModel();
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      sa = pickWord();
      if (r < 4)      begin sf = 3'b000; sa[1:0] = 2'($urandom_range(0, 3)); end
      else if (r < 7) begin sf = 3'b001; sa[1] = 1'($urandom_range(0, 1)); end
      else if (r < 9) sf = 3'b010;
      else            begin sf = 3'b011; sa[1:0] = 2'($urandom_range(0, 3)); end
      lf = ld_opts[$urandom_range(0, 5)];
      la = pickWord();
      if (lf == 3'b000 || lf == 3'b100 || lf == 3'b011) la[1:0] = 2'($urandom_range(0, 3));
      else if (lf != 3'b010) la[1] = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 2) != 0), sa, sf, $urandom(),
                    1'($urandom_range(0, 4) != 0), la, lf,
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
